// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: one registered output slot between the instruction
// source and the ALU, with same-edge write-back bypass and hold-time operand coherence.
module operand_fetch #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,

    output logic [ADDR_W-1:0]  ra,
    output logic [ADDR_W-1:0]  rb,
    input  logic [DATA_W-1:0]  read_a,
    input  logic [DATA_W-1:0]  read_b,

    input  logic               wb_we,
    input  logic [ADDR_W-1:0]  wb_wa,
    input  logic [DATA_W-1:0]  wb_wd,

    input  logic               flush,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_op,
    output logic [ADDR_W-1:0]  out_rd,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b
);

    localparam int unsigned OpW = 4;

    logic [OpW-1:0]    in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;

    logic              valid_q, valid_d;
    logic [OpW-1:0]    op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic              accept;

    assign in_op  = in_instr[INSTR_W-1 -: OpW];
    assign in_rd  = in_instr[3*ADDR_W-1 -: ADDR_W];
    assign in_rs1 = in_instr[2*ADDR_W-1 -: ADDR_W];
    assign in_rs2 = in_instr[ADDR_W-1:0];

    // Register-file read addresses follow the incoming word directly, even in reset.
    assign ra = in_rs1;
    assign rb = in_rs2;

    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        a_d     = a_q;
        b_d     = b_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            op_d    = in_op;
            rd_d    = in_rd;
            rs1_d   = in_rs1;
            rs2_d   = in_rs2;
            // The reg_file write lands on this same edge, so its read data is stale.
            a_d     = (wb_we && (wb_wa == in_rs1)) ? wb_wd : read_a;
            b_d     = (wb_we && (wb_wa == in_rs2)) ? wb_wd : read_b;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: track write-backs to the held sources so the ALU sees fresh data.
            if (wb_we && (wb_wa == rs1_q)) a_d = wb_wd;
            if (wb_we && (wb_wa == rs2_q)) b_d = wb_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= valid_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op    = op_q;
    assign out_rd    = rd_q;
    assign out_a     = a_q;
    assign out_b     = b_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural reg_file, scoreboard queue of expected outputs,
// plus directed checks for the bypass, stall, flush and async-reset cases.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [3:0]  ra, rb;
    logic [7:0]  read_a, read_b;
    logic        wb_we;
    logic [3:0]  wb_wa;
    logic [7:0]  wb_wd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic [3:0]  out_rd;
    logic [7:0]  out_a, out_b;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    exp_t sbq[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_handoff = 0;
    int   hand_base;

    logic [7:0] rf [16];

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .ra        (ra),
        .rb        (rb),
        .read_a    (read_a),
        .read_b    (read_b),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_wd     (wb_wd),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_rd    (out_rd),
        .out_a     (out_a),
        .out_b     (out_b)
    );

    // Reg file: async read, sync write, preloaded with reg[i] = i*0x11 while in reset.
    assign read_a = rf[ra];
    assign read_b = rf[rb];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'(i * 17);
        end else if (wb_we) begin
            rf[wb_wa] <= wb_wd;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare the head entry, then apply this cycle's edge effects.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_t t;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            exp_rdy = !flush && (sbq.size() == 0 || out_ready);
            check_val("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
            check_val("sb_out_valid", 32'(out_valid), 32'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                t = sbq[0];
                check_val("sb_op", 32'(out_op), 32'(t.op));
                check_val("sb_rd", 32'(out_rd), 32'(t.rd));
                check_val("sb_a", 32'(out_a), 32'(t.a));
                check_val("sb_b", 32'(out_b), 32'(t.b));
            end
            if (flush) begin
                if (sbq.size() != 0) void'(sbq.pop_front());
            end else begin
                if (sbq.size() != 0) begin
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        n_handoff++;
                    end else if (wb_we) begin
                        t = sbq[0];
                        if (wb_wa == t.rs1) t.a = wb_wd;
                        if (wb_wa == t.rs2) t.b = wb_wd;
                        sbq[0] = t;
                    end
                end
                if (in_valid && exp_rdy) begin
                    t.op  = in_instr[15:12];
                    t.rd  = in_instr[11:8];
                    t.rs1 = in_instr[7:4];
                    t.rs2 = in_instr[3:0];
                    t.a   = (wb_we && wb_wa == t.rs1) ? wb_wd : rf[t.rs1];
                    t.b   = (wb_we && wb_wa == t.rs2) ? wb_wd : rf[t.rs2];
                    sbq.push_back(t);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] stream [4];
        stream = '{16'h0012, 16'h0134, 16'h0256, 16'h0378};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 16'h00ab;
        wb_we     = 1'b0;
        wb_wa     = '0;
        wb_wd     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_op", 32'(out_op), 32'd0);
        check_val("rst_rd", 32'(out_rd), 32'd0);
        check_val("rst_a", 32'(out_a), 32'd0);
        check_val("rst_b", 32'(out_b), 32'd0);
        check_val("rst_ra", 32'(ra), 32'ha);
        check_val("rst_rb", 32'(rb), 32'hb);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Basic fetch
        in_valid = 1'b1;
        in_instr = 16'h2135;
        #1;
        check_val("t1_ra", 32'(ra), 32'd3);
        check_val("t1_rb", 32'(rb), 32'd5);
        cyc();
        // Same-edge bypass
        in_instr = 16'h1067;
        wb_we    = 1'b1;
        wb_wa    = 4'd6;
        wb_wd    = 8'haa;
        check_val("t1_valid", 32'(out_valid), 32'd1);
        check_val("t1_op", 32'(out_op), 32'd2);
        check_val("t1_rd", 32'(out_rd), 32'd1);
        check_val("t1_a", 32'(out_a), 32'h33);
        check_val("t1_b", 32'(out_b), 32'h55);
        cyc();
        in_valid = 1'b0;
        wb_we    = 1'b0;
        check_val("t2_a", 32'(out_a), 32'haa);
        check_val("t2_b", 32'(out_b), 32'h77);
        cyc();

        // Stall coherence
        in_valid  = 1'b1;
        in_instr  = 16'h3489;
        out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        check_val("t3_a0", 32'(out_a), 32'h88);
        check_val("t3_b0", 32'(out_b), 32'h99);
        cyc();
        wb_we = 1'b1;
        wb_wa = 4'd9;
        wb_wd = 8'h5c;
        cyc();
        wb_wa = 4'd2;
        wb_wd = 8'h11;
        check_val("t3_b", 32'(out_b), 32'h5c);
        check_val("t3_a", 32'(out_a), 32'h88);
        check_val("t3_rdy", 32'(in_ready), 32'd0);
        cyc();
        wb_we = 1'b0;
        check_val("t3_nosrc_a", 32'(out_a), 32'h88);
        check_val("t3_nosrc_b", 32'(out_b), 32'h5c);
        check_val("t3_op", 32'(out_op), 32'd3);
        check_val("t3_rd", 32'(out_rd), 32'd4);
        out_ready = 1'b1;
        cyc();
        check_val("t3_handoff", 32'(out_valid), 32'd0);

        // Back-to-back stream
        hand_base = n_handoff;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = stream[i];
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        cyc();
        check_val("t4_handoffs", 32'(n_handoff - hand_base), 32'd4);

        // Flush while held
        in_valid  = 1'b1;
        in_instr  = 16'h4abc;
        out_ready = 1'b0;
        cyc();
        in_instr = 16'h5def;
        flush    = 1'b1;
        #1;
        check_val("t5_rdy", 32'(in_ready), 32'd0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("t5_valid", 32'(out_valid), 32'd0);
        cyc();
        check_val("t5_noconsume", 32'(out_valid), 32'd0);

        // Async reset between edges
        in_valid = 1'b1;
        in_instr = 16'h6123;
        cyc();
        in_valid = 1'b0;
        check_val("t6_pre", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_valid", 32'(out_valid), 32'd0);
        check_val("t6_op", 32'(out_op), 32'd0);
        check_val("t6_a", 32'(out_a), 32'd0);
        check_val("t6_b", 32'(out_b), 32'd0);
        cyc();
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 16'h7045;
        cyc();
        in_valid = 1'b0;
        check_val("t6_op2", 32'(out_op), 32'd7);
        check_val("t6_rd2", 32'(out_rd), 32'd0);
        check_val("t6_a2", 32'(out_a), 32'h44);
        check_val("t6_b2", 32'(out_b), 32'h55);
        cyc();
        cyc();
        check_val("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
